disp_scan_mux: RTL and testbench
================================

// Module: disp_scan_mux
// PURPOSE
//   Time-multiplexed scanner for the 4-digit common-anode 7-segment display.
//   Sits directly upstream of the hex-to-segment decoder: takes a 16-bit hex
//   word plus per-digit point/blank flags and produces one digit at a time
//   (nibble, point, LE) with the matching active-low anode. Updates are
//   double-buffered so a new value never appears partway through a frame.
// PARAMETERS
//   SCAN_DIV  50000  clk cycles each digit is selected (>= 2)
//   GUARD     16     anode-off cycles at the start of each digit slot (anti-ghost, < SCAN_DIV)
// PORTS
//   clk        in   1   system clock; all state changes on rising edge
//   rst        in   1   asynchronous reset, active-high
//   hexs       in   16  value to show; [15:12]=digit 3 (left) .. [3:0]=digit 0 (right)
//   points     in   4   per-digit decimal-point request, 1 = lit, bit i = digit i
//   blank      in   4   per-digit blank request, 1 = blank, bit i = digit i
//   load       in   1   1-cycle strobe: capture hexs/points/blank into shadow regs
//   lz_en      in   1   1 = suppress leading zeros (level, sampled every cycle)
//   dig        out  4   nibble to decoder D3..D0
//   point      out  1   point request to decoder (1 = lit; decoder inverts)
//   le_out     out  1   decoder LE; 1 = digit blank
//   an         out  4   anode enables, active-low, an[i] = digit i
//   frame_tick out  1   1-cycle pulse when scan wraps digit 3 -> digit 0
// BEHAVIOUR
//   - Reset (async, immediate): prescaler=0, idx=0, shadow and display hex/points=0,
//     shadow and display blank=4'hF; outputs an=4'b1111, dig=0, point=0, le_out=1,
//     frame_tick=0. Nothing is lit until the first load reaches the display regs.
//   - Prescaler counts 0..SCAN_DIV-1 and wraps; at terminal count idx advances 0->1->2->3->0.
//   - Shadow regs: on load, shadow <= {hexs,points,blank}. A later load overwrites (last wins).
//   - Display regs: updated from shadow only on the cycle idx wraps 3->0. If load and the
//     wrap occur on the same cycle, the display takes the new inputs directly (bypass).
//     Without a wrap, a load changes the shadow only; the display is untouched.
//   - frame_tick high for exactly the cycle after the 3->0 wrap edge (coincident with the
//     new display regs becoming visible).
//   - All outputs are registered: an idx change at edge T is visible on dig/an at T+1.
//   - Guard: while prescaler < GUARD, an=4'b1111; otherwise an = ~(4'b0001 << idx).
//     dig/point/le_out follow idx regardless of the guard.
//   - Leading-zero suppression (lz_en=1): digit k in {3,2,1} is suppressed when the display
//     nibbles k..3 are all 0. Digit 0 is never suppressed.
//   - le_out = display blank[idx] | suppressed(idx). point = display points[idx], also
//     driven for blanked or suppressed digits.
//   - Exactly one an bit is low outside the guard window; never more than one.
//   - Reset mid-frame: immediate return to the reset state; scan restarts at digit 0.
// TESTING  (sim with SCAN_DIV=4, GUARD=1)
//   1 reset asserted mid-scan -> an=1111, le_out=1, frame_tick=0 with no clock edge;
//     after release, digit 0 is selected first.
//   2 load hexs=16'h1234, points=4'b0100, blank=0 -> after frame_tick: an=1110 with dig=4;
//     an=1011 with dig=2 and point=1; order 4,3,2,1 repeating.
//   3 lz_en=1, hexs=16'h0050 -> digits 3,2 le_out=1; digit 1 dig=5, le_out=0;
//     digit 0 dig=0, le_out=0. With hexs=16'h0000 only digit 0 lit.
//   4 load 16'hAAAA while 16'h1234 shows, mid-frame -> rest of frame shows 1234;
//     AAAA appears from the next frame_tick.
//   5 load on the exact wrap cycle -> the new value is shown from digit 0 of that frame;
//     two loads in one frame -> only the last is shown.
//   6 guard check -> in every digit slot, the first cycle has an=1111 and the next 3 cycles
//     have one low bit; never two low bits at once.

Source files
------------

// File: rtl/disp_scan_mux.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// Double-buffered value registers, per-digit anti-ghost guard and leading-zero blanking.
//
// state | meaning
// DIG0  | rightmost digit (hexs[3:0]) selected
// DIG1  | digit 1 (hexs[7:4]) selected
// DIG2  | digit 2 (hexs[11:8]) selected
// DIG3  | leftmost digit (hexs[15:12]) selected; leaving it ends the frame
module disp_scan_mux #(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  blank,
    input  logic        load,
    input  logic        lz_en,
    output logic [3:0]  dig,
    output logic        point,
    output logic        le_out,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);

    localparam logic [1:0] DIG0 = 2'd0;
    localparam logic [1:0] DIG1 = 2'd1;
    localparam logic [1:0] DIG2 = 2'd2;
    localparam logic [1:0] DIG3 = 2'd3;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic          tc;
    logic          wrap;

    logic [15:0]   shd_hex;
    logic [3:0]    shd_pts;
    logic [3:0]    shd_blank;
    logic [15:0]   disp_hex;
    logic [3:0]    disp_pts;
    logic [3:0]    disp_blank;

    logic [3:0]    nib_sel;
    logic          pt_sel;
    logic          blank_sel;
    logic          sup_sel;
    logic [3:0]    an_sel;

    assign tc   = (presc == PRESC_LAST);
    assign wrap = tc && (idx == DIG3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tc) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        idx_nxt = idx;
        if (tc) begin
            case (idx)
                DIG0:    idx_nxt = DIG1;
                DIG1:    idx_nxt = DIG2;
                DIG2:    idx_nxt = DIG3;
                default: idx_nxt = DIG0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= DIG0;
        end else begin
            idx <= idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd_hex   <= '0;
            shd_pts   <= '0;
            shd_blank <= 4'hF;
        end else if (load) begin
            shd_hex   <= hexs;
            shd_pts   <= points;
            shd_blank <= blank;
        end
    end

    // A load landing on the wrap cycle bypasses the shadow so it is not lost for a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_hex   <= '0;
            disp_pts   <= '0;
            disp_blank <= 4'hF;
        end else if (wrap) begin
            if (load) begin
                disp_hex   <= hexs;
                disp_pts   <= points;
                disp_blank <= blank;
            end else begin
                disp_hex   <= shd_hex;
                disp_pts   <= shd_pts;
                disp_blank <= shd_blank;
            end
        end
    end

    always_comb begin
        nib_sel   = disp_hex[{idx, 2'b00} +: 4];
        pt_sel    = disp_pts[idx];
        blank_sel = disp_blank[idx];
        sup_sel   = 1'b0;
        case (idx)
            DIG3:    sup_sel = (disp_hex[15:12] == 4'h0);
            DIG2:    sup_sel = (disp_hex[15:8] == 8'h00);
            DIG1:    sup_sel = (disp_hex[15:4] == 12'h000);
            default: sup_sel = 1'b0;
        endcase
        sup_sel = sup_sel & lz_en;
        an_sel  = (presc < GUARD_END) ? 4'b1111 : ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= 4'b1111;
            dig        <= '0;
            point      <= 1'b0;
            le_out     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_sel;
            dig        <= nib_sel;
            point      <= pt_sel;
            le_out     <= blank_sel | sup_sel;
            frame_tick <= wrap;
        end
    end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Bench for disp_scan_mux: directed scenarios plus random loads, checked against
// an edge-count model of the scan timeline and the double-buffered display value.
module tb_disp_scan_mux;

    localparam int SD = 4;
    localparam int GD = 1;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] hexs = '0;
    logic [3:0]  points = '0;
    logic [3:0]  blank = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  dig;
    logic        point;
    logic        le_out;
    logic [3:0]  an;
    logic        frame_tick;

    int          n_checks = 0;
    int          n_fail = 0;
    int          e = 0;
    logic        lz_m = 1'b0;
    logic [23:0] shadow_m;
    logic [23:0] disp_m;

    disp_scan_mux #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk(clk), .rst(rst), .hexs(hexs), .points(points), .blank(blank),
        .load(load), .lz_en(lz_en), .dig(dig), .point(point), .le_out(le_out),
        .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp_v, e);
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare outputs on the falling edge.
    task automatic step(input logic ld, input logic [15:0] h, input logic [3:0] p,
                        input logic [3:0] b, input logic lz);
        int          ph;
        int          id;
        logic [15:0] dh;
        logic [3:0]  ex_an;
        logic [3:0]  ex_dig;
        logic        ex_pt;
        logic        ex_le;
        logic        sup;
        hexs = h; points = p; blank = b; load = ld; lz_en = lz;
        ph = e % SD;
        id = (e / SD) % 4;
        dh = disp_m[23:8];
        ex_an  = (ph < GD) ? 4'b1111 : ~(4'b0001 << id);
        ex_dig = 4'((dh >> (id * 4)) & 16'hF);
        ex_pt  = disp_m[4 + id];
        sup    = lz && (id != 0) && ((dh >> (id * 4)) == 16'h0);
        ex_le  = disp_m[id] | sup;
        @(posedge clk);
        e++;
        if (ld) shadow_m = {h, p, b};
        if (e % FR == 0) disp_m = shadow_m;
        @(negedge clk);
        check("an", 16'(an), 16'(ex_an));
        check("dig", 16'(dig), 16'(ex_dig));
        check("point", 16'(point), 16'(ex_pt));
        check("le_out", 16'(le_out), 16'(ex_le));
        check("frame_tick", 16'(frame_tick), 16'(e % FR == 0));
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0, lz_m);
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < FR && (e % FR) != phase; i++) step(1'b0, 16'h0, 4'h0, 4'h0, lz_m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_an", 16'(an), 16'hF);
        check("rst_le", 16'(le_out), 16'h1);
        check("rst_ft", 16'(frame_tick), 16'h0);
        check("rst_dig", 16'(dig), 16'h0);
        check("rst_point", 16'(point), 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        e = 0;
        shadow_m = {16'h0, 4'h0, 4'hF};
        disp_m   = shadow_m;
    endtask

    initial begin
        do_reset();
        idle(20);

        step(1'b1, 16'h1234, 4'b0100, 4'h0, lz_m);
        idle(40);

        lz_m = 1'b1;
        step(1'b1, 16'h0050, 4'h0, 4'h0, lz_m);
        idle(36);
        step(1'b1, 16'h0000, 4'h0, 4'h0, lz_m);
        idle(36);
        lz_m = 1'b0;

        step(1'b1, 16'h1234, 4'b0100, 4'h0, lz_m);
        run_to(0);
        idle(FR);
        run_to(5);
        step(1'b1, 16'hAAAA, 4'h0, 4'h0, lz_m);
        idle(2 * FR);

        run_to(FR - 1);
        step(1'b1, 16'hBEEF, 4'b1010, 4'b0010, lz_m);
        idle(FR);

        run_to(2);
        step(1'b1, 16'h1111, 4'h1, 4'h0, lz_m);
        idle(3);
        step(1'b1, 16'h2222, 4'h8, 4'h4, lz_m);
        idle(2 * FR);

        run_to(7);
        do_reset();
        idle(2 * FR);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) lz_m = ~lz_m;
            step(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), 4'($urandom), lz_m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
